// File: rtl/neuron_pkg.sv
// Shared fixed-point definitions for the neuron datapath and the sigmoid stage
// it feeds: Q8.8 width, saturation limits, the clamp helper and the control
// state encoding.
package neuron_pkg;

    localparam int Q_W = 16;
    localparam int Q_FRAC = 8;

    localparam logic signed [Q_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [Q_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_ARG = 2'd0,
        ST_RES = 2'd1,
        ST_ERR = 2'd2,
        ST_UPD = 2'd3
    } state_t;

    // Clamp a wide signed value into Q8.8; never wraps.
    function automatic logic signed [Q_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return SAT_MAX;
        end else if (v < -32'sd32768) begin
            return SAT_MIN;
        end else begin
            return v[Q_W-1:0];
        end
    endfunction

endpackage

// File: rtl/neuron_if.sv
// Strobe/ready streams of the neuron: activations in, weighted sum out,
// error feedback in.
interface neuron_if;
    import neuron_pkg::*;

    logic                  arg_stb;
    logic [7:0]            arg_dat;
    logic                  arg_rdy;

    logic                  res_stb;
    logic signed [Q_W-1:0] res_dat;
    logic                  res_rdy;

    logic                  err_stb;
    logic signed [Q_W-1:0] err_dat;
    logic                  err_rdy;

    // The neuron side of every stream.
    modport slave (
        input  arg_stb, arg_dat, res_rdy, err_stb, err_dat,
        output arg_rdy, res_stb, res_dat, err_rdy
    );

    // The environment side: sources activations/errors, sinks results.
    modport master (
        output arg_stb, arg_dat, res_rdy, err_stb, err_dat,
        input  arg_rdy, res_stb, res_dat, err_rdy
    );

endinterface

// File: rtl/neuron.sv
// Single trainable neuron: accumulates x[i]*w[i] over an N-element activation
// vector, emits the saturated Q8.8 sum, and when training is enabled takes an
// error value and applies a delta-rule update to each weight, one per cycle.
module neuron
    import neuron_pkg::*;
#(
    parameter int N     = 4,
    parameter int SHIFT = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    neuron_if.slave  bus
);

    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 24 + IW;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IW-1:0]             r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [Q_W-1:0]     r_w [N];
    logic [7:0]                r_x [N];
    logic signed [Q_W-1:0]     r_err;
    logic                      r_res_stb;
    logic signed [Q_W-1:0]     r_res_dat;

    logic                      w_arg_ack;
    logic                      w_res_ack;
    logic                      w_err_ack;
    logic                      w_last;
    logic                      w_enter_arg;
    logic signed [24:0]        w_mac_prod;
    logic signed [ACC_W-1:0]   w_mac_ext;
    logic signed [ACC_W-1:0]   w_acc_shift;
    logic signed [Q_W-1:0]     w_sum_sat;
    logic signed [24:0]        w_upd_prod;
    logic signed [24:0]        w_upd_delta;
    logic signed [31:0]        w_upd_sum;
    logic signed [Q_W-1:0]     w_upd_sat;

    // Ready lines are pure decodes of the state, so they also take their
    // reset values directly from the reset state.
    assign bus.arg_rdy = (r_state == ST_ARG);
    assign bus.err_rdy = (r_state == ST_ERR);
    assign bus.res_stb = r_res_stb;
    assign bus.res_dat = r_res_dat;

    assign w_arg_ack   = (r_state == ST_ARG) && bus.arg_stb;
    assign w_res_ack   = r_res_stb && bus.res_rdy;
    assign w_err_ack   = (r_state == ST_ERR) && bus.err_stb;
    assign w_last      = (r_idx == IW'(N - 1));
    assign w_enter_arg = (w_state_next == ST_ARG) && (r_state != ST_ARG);

    // Unsigned activation times signed weight; fits in 24 bits signed.
    assign w_mac_prod  = $signed({1'b0, bus.arg_dat}) * r_w[r_idx];
    assign w_mac_ext   = ACC_W'(w_mac_prod);

    // Drop the Q0.8 fraction of the activation, then clamp to Q8.8.
    assign w_acc_shift = r_acc >>> Q_FRAC;
    assign w_sum_sat   = sat16(32'(w_acc_shift));

    // Delta rule: err * x scaled by 2^-(8+SHIFT), arithmetic (floor) shift.
    assign w_upd_prod  = r_err * $signed({1'b0, r_x[r_idx]});
    assign w_upd_delta = w_upd_prod >>> (Q_FRAC + SHIFT);
    assign w_upd_sum   = 32'(r_w[r_idx]) + 32'(w_upd_delta);
    assign w_upd_sat   = sat16(w_upd_sum);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_ARG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; training enable only matters at result acknowledge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ARG: if (w_arg_ack && w_last) w_state_next = ST_RES;
            ST_RES: if (w_res_ack) w_state_next = en ? ST_ERR : ST_ARG;
            ST_ERR: if (w_err_ack) w_state_next = ST_UPD;
            ST_UPD: if (w_last) w_state_next = ST_ARG;
            default: w_state_next = ST_ARG;
        endcase
    end

    // Element index shared by accumulation and weight update; wraps N-1 -> 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_arg_ack || (r_state == ST_UPD)) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end else if (w_err_ack) begin
            r_idx <= '0;
        end
    end

    // Accumulator: cleared whenever ARG is (re)entered, so a vector never
    // inherits a previous sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (w_enter_arg) begin
            r_acc <= '0;
        end else if (w_arg_ack) begin
            r_acc <= r_acc + w_mac_ext;
        end
    end

    // Input buffer and weights; weights only change during UPD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            if (w_arg_ack) begin
                r_x[r_idx] <= bus.arg_dat;
            end
            if (r_state == ST_UPD) begin
                r_w[r_idx] <= w_upd_sat;
            end
        end
    end

    // Result register: raised on the first RES cycle, held until acknowledged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_stb <= 1'b0;
            r_res_dat <= '0;
        end else if ((r_state == ST_RES) && !r_res_stb) begin
            r_res_stb <= 1'b1;
            r_res_dat <= w_sum_sat;
        end else if (w_res_ack) begin
            r_res_stb <= 1'b0;
        end
    end

    // Error latch for the update pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else if (w_err_ack) begin
            r_err <= bus.err_dat;
        end
    end

endmodule

// File: tb/tb_neuron.sv
// Directed and randomized checks of the neuron: reset values, inference,
// training, saturation, backpressure, mid-vector reset and a model comparison.
module tb_neuron;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    neuron_if ifc();

    neuron #(.N(4), .SHIFT(2)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic err_rdy_seen = 1'b0;
    int mw [4];

    // Flags any err_rdy assertion, for the inference-only scenario.
    always @(posedge clk) begin
        if (ifc.err_rdy === 1'b1) err_rdy_seen <= 1'b1;
    end

    function automatic int msat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        ifc.arg_stb = 1'b0;
        ifc.arg_dat = '0;
        ifc.res_rdy = 1'b0;
        ifc.err_stb = 1'b0;
        ifc.err_dat = '0;
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic put_arg(input logic [7:0] d, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        ifc.arg_stb = 1'b1;
        ifc.arg_dat = d;
        n = 0;
        while (ifc.arg_rdy !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++;
            $display("FAIL arg_timeout: arg_rdy=%b, required 1 within 200 cycles", ifc.arg_rdy);
        end
        @(posedge clk);
        #1;
        ifc.arg_stb = 1'b0;
    endtask

    task automatic put_vec(input logic [31:0] xv, input int maxgap);
        for (int i = 0; i < 4; i++)
            put_arg(xv[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic get_res(input int hold, output logic [15:0] v);
        int n;
        ifc.res_rdy = 1'b0;
        n = 0;
        while (ifc.res_stb !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++;
            $display("FAIL res_timeout: res_stb=%b, required 1 within 200 cycles", ifc.res_stb);
        end
        repeat (hold) begin @(posedge clk); #1; end
        v = ifc.res_dat;
        ifc.res_rdy = 1'b1;
        @(posedge clk);
        #1;
        ifc.res_rdy = 1'b0;
    endtask

    task automatic put_err(input logic [15:0] e, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        ifc.err_stb = 1'b1;
        ifc.err_dat = e;
        n = 0;
        while (ifc.err_rdy !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++;
            $display("FAIL err_timeout: err_rdy=%b, required 1 within 200 cycles", ifc.err_rdy);
        end
        @(posedge clk);
        #1;
        ifc.err_stb = 1'b0;
        // UPD takes 4 cycles before ARG is back.
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic train(input logic [31:0] xv, input logic [15:0] e);
        logic [15:0] v;
        en = 1'b1;
        put_vec(xv, 0);
        get_res(0, v);
        en = 1'b0;
        put_err(e, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.arg_stb = 1'b0; ifc.arg_dat = '0; ifc.res_rdy = 1'b0;
        ifc.err_stb = 1'b0; ifc.err_dat = '0; en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifc.arg_rdy !== 1'b1) $display("FAIL reset_arg_rdy: got %b, required 1", ifc.arg_rdy);
        else passes++;
        checks++;
        if (ifc.err_rdy !== 1'b0) $display("FAIL reset_err_rdy: got %b, required 0", ifc.err_rdy);
        else passes++;
        checks++;
        if (ifc.res_stb !== 1'b0) $display("FAIL reset_res_stb: got %b, required 0", ifc.res_stb);
        else passes++;
        checks++;
        if (ifc.res_dat !== 16'h0000) $display("FAIL reset_res_dat: got %h, required 0000", ifc.res_dat);
        else passes++;
        checks++;
        if (dut.r_idx !== 2'd0 || dut.r_acc !== '0)
            $display("FAIL reset_idx_acc: idx=%0d acc=%0d, required 0/0", dut.r_idx, dut.r_acc);
        else passes++;
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_no_train();
        logic [15:0] v;
        do_reset();
        err_rdy_seen = 1'b0;
        put_vec(32'hFFFF_FFFF, 0);
        checks++;
        if (ifc.res_stb !== 1'b0) $display("FAIL res_latency_low: got %b, required 0 on RES entry", ifc.res_stb);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (ifc.res_stb !== 1'b1) $display("FAIL res_latency_high: got %b, required 1 one cycle after RES entry", ifc.res_stb);
        else passes++;
        get_res(0, v);
        checks++;
        if (v !== 16'h0000) $display("FAIL no_train_res: got %h, required 0000", v);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifc.arg_rdy !== 1'b1 || err_rdy_seen !== 1'b0)
            $display("FAIL no_train_back_to_arg: arg_rdy=%b err_rdy_seen=%b, required 1/0", ifc.arg_rdy, err_rdy_seen);
        else passes++;
        $display("test_no_train done res=%h", v);
    endtask

    task automatic test_train();
        logic [15:0] v;
        do_reset();
        train(32'hFFFF_FFFF, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.r_w[i] !== 16'h003F) $display("FAIL train_w%0d: got %h, required 003F", i, dut.r_w[i]);
            else passes++;
        end
        en = 1'b0;
        put_vec(32'h8080_8080, 0);
        get_res(0, v);
        checks++;
        if (v !== 16'h007E) $display("FAIL train_res: got %h, required 007E", v);
        else passes++;
        $display("test_train done res=%h", v);
    endtask

    task automatic test_saturate();
        logic [15:0] v;
        do_reset();
        repeat (5) train(32'hFFFF_FFFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.r_w[i] !== 16'h7FFF) $display("FAIL sat_pos_w%0d: got %h, required 7FFF", i, dut.r_w[i]);
            else passes++;
        end
        put_vec(32'hFFFF_FFFF, 0);
        get_res(0, v);
        checks++;
        if (v !== 16'h7FFF) $display("FAIL sat_pos_res: got %h, required 7FFF", v);
        else passes++;
        do_reset();
        repeat (5) train(32'hFFFF_FFFF, 16'h8000);
        checks++;
        if (dut.r_w[2] !== 16'h8000) $display("FAIL sat_neg_w2: got %h, required 8000", dut.r_w[2]);
        else passes++;
        put_vec(32'hFFFF_FFFF, 0);
        get_res(0, v);
        checks++;
        if (v !== 16'h8000) $display("FAIL sat_neg_res: got %h, required 8000", v);
        else passes++;
        $display("test_saturate done res=%h", v);
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        train(32'hFFFF_FFFF, 16'h0100);
        put_vec(32'h8080_8080, 0);
        n = 0;
        while (ifc.res_stb !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        for (int c = 0; c < 10; c++) begin
            en = c[0];
            checks++;
            if (ifc.res_stb !== 1'b1 || ifc.res_dat !== 16'h007E || ifc.arg_rdy !== 1'b0)
                $display("FAIL bp_hold%0d: stb=%b dat=%h arg_rdy=%b, required 1/007E/0", c, ifc.res_stb, ifc.res_dat, ifc.arg_rdy);
            else passes++;
            @(posedge clk); #1;
        end
        en = 1'b0;
        ifc.res_rdy = 1'b1;
        @(posedge clk); #1;
        ifc.res_rdy = 1'b0;
        checks++;
        if (ifc.res_stb !== 1'b0) $display("FAIL bp_drop: res_stb=%b, required 0 after ack", ifc.res_stb);
        else passes++;
        checks++;
        if (ifc.arg_rdy !== 1'b1 || ifc.err_rdy !== 1'b0)
            $display("FAIL bp_en_at_ack: arg_rdy=%b err_rdy=%b, required 1/0", ifc.arg_rdy, ifc.err_rdy);
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ifc.res_stb !== 1'b0) $display("FAIL bp_single: res_stb=%b, required 0", ifc.res_stb);
        else passes++;
        $display("test_backpressure done");
    endtask

    task automatic test_mid_reset();
        logic [15:0] v;
        do_reset();
        train(32'hFFFF_FFFF, 16'h0100);
        put_arg(8'h80, 0);
        put_arg(8'h80, 0);
        rst = 1'b0;
        #2;
        checks++;
        if (ifc.arg_rdy !== 1'b1 || ifc.res_stb !== 1'b0 || ifc.err_rdy !== 1'b0)
            $display("FAIL midrst_ports: arg_rdy=%b res_stb=%b err_rdy=%b, required 1/0/0", ifc.arg_rdy, ifc.res_stb, ifc.err_rdy);
        else passes++;
        checks++;
        if (dut.r_idx !== 2'd0 || dut.r_acc !== '0 || dut.r_w[0] !== 16'h0000 || dut.r_x[1] !== 8'h00)
            $display("FAIL midrst_state: idx=%0d acc=%0d w0=%h x1=%h, required 0/0/0000/00", dut.r_idx, dut.r_acc, dut.r_w[0], dut.r_x[1]);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        train(32'h0000_00FF, 16'h0100);
        checks++;
        if (dut.r_w[0] !== 16'h003F || dut.r_w[1] !== 16'h0000)
            $display("FAIL midrst_elem0: w0=%h w1=%h, required 003F/0000", dut.r_w[0], dut.r_w[1]);
        else passes++;
        put_vec(32'h0000_0080, 0);
        get_res(0, v);
        checks++;
        if (v !== 16'h001F) $display("FAIL midrst_res: got %h, required 001F", v);
        else passes++;
        $display("test_mid_reset done res=%h", v);
    endtask

    task automatic test_random();
        logic [31:0] xv;
        logic [15:0] e;
        logic [15:0] v;
        int s;
        int exp_v;
        logic do_en;
        do_reset();
        for (int i = 0; i < 4; i++) mw[i] = 0;
        for (int k = 0; k < 1000; k++) begin
            xv = $urandom;
            do_en = ($urandom_range(0, 2) == 0);
            s = 0;
            for (int i = 0; i < 4; i++) s += int'(xv[i*8 +: 8]) * mw[i];
            exp_v = msat(s >>> 8);
            put_vec(xv, 2);
            en = do_en;
            get_res(int'($urandom_range(0, 3)), v);
            en = 1'b0;
            checks++;
            if (v !== 16'(exp_v))
                $display("FAIL rand_res%0d: got %h, required %h (x=%h)", k, v, 16'(exp_v), xv);
            else passes++;
            if (do_en) begin
                if ($urandom_range(0, 3) == 0) e = 16'($urandom);
                else e = 16'($signed(11'($urandom)));
                put_err(e, int'($urandom_range(0, 2)));
                for (int i = 0; i < 4; i++)
                    mw[i] = msat(mw[i] + ((int'($signed(e)) * int'(xv[i*8 +: 8])) >>> 10));
            end
        end
        $display("test_random done");
    endtask

    initial begin
        ifc.arg_stb = 1'b0;
        ifc.arg_dat = '0;
        ifc.res_rdy = 1'b0;
        ifc.err_stb = 1'b0;
        ifc.err_dat = '0;
        test_reset();
        test_no_train();
        test_train();
        test_saturate();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/neuron.md
NEURON -- requirements
Module: neuron

Interface
REQ-001 SHALL have parameter N, default 4: number of inputs per vector (power of two, 2..16).
REQ-002 SHALL have parameter SHIFT, default 2: learning-rate right shift applied to weight deltas.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1: training enable, sampled at result acknowledge.
REQ-006 SHALL have port arg_stb, input, 1: input activation valid.
REQ-007 SHALL have port arg_dat, input, 8: activation, unsigned Q0.8, one element per beat, element 0 first.
REQ-008 SHALL have port arg_rdy, output, 1: ready for an activation.
REQ-009 SHALL have port res_stb, output, 1: weighted-sum valid.
REQ-010 SHALL have port res_dat, output, 16: weighted sum, signed Q8.8, feeds the sigmoid stage's argument port.
REQ-011 SHALL have port res_rdy, input, 1: downstream ready.
REQ-012 SHALL have port err_stb, input, 1: error valid.
REQ-013 SHALL have port err_dat, input, 16: error, signed Q8.8, taken from the sigmoid stage's feedback port.
REQ-014 SHALL have port err_rdy, output, 1: ready for an error.

Function
REQ-015 SHALL transfer on any interface only in a cycle where its stb and rdy are both 1 (ack).
REQ-016 SHALL hold weights w[0..N-1], signed 16-bit Q8.8, and an input buffer x[0..N-1], 8-bit.
REQ-017 SHALL implement states ARG, RES, ERR and UPD; ARG is entered after reset.
REQ-018 In ARG, SHALL assert arg_rdy; on each ack, SHALL store x[i], add the 24-bit product x[i]*w[i] (sign-extended) into a (24+log2 N)-bit accumulator, and increment i.
REQ-019 On the ack of element N-1, SHALL go to RES; the accumulator SHALL clear at entry to ARG.
REQ-020 res_stb SHALL rise one cycle after RES is entered, SHALL stay 1 with res_dat stable until ack, and SHALL drop the cycle after ack.
REQ-021 res_dat SHALL be the accumulator arithmetically shifted right by 8, saturated to [0x8000, 0x7FFF].
REQ-022 On res ack: if en=1, SHALL go to ERR; otherwise SHALL go to ARG.
REQ-023 In ERR, SHALL assert err_rdy; on ack, SHALL latch err_dat and go to UPD.
REQ-024 In UPD, SHALL update one weight per cycle, i=0..N-1: w[i] <= sat16(w[i] + ((err*x[i]) >>> (8+SHIFT))). The product SHALL be 25-bit signed and the shift arithmetic; SHALL then return to ARG (N cycles total).
REQ-025 arg_rdy and err_rdy SHALL be 0 in every state other than their own; en changes outside res ack SHALL have no effect.
REQ-026 The element index SHALL wrap from N-1 to 0; no partial vector SHALL ever be emitted.
REQ-027 Saturation SHALL clamp and never wrap, both for the sum and for the weights.

Reset
REQ-028 While rst=0, SHALL force: state ARG, index 0, accumulator 0, all w and x 0, err 0, res_stb 0, arg_rdy 1, err_rdy 0.
REQ-029 Reset mid-vector or mid-update SHALL discard the partial work; the first ack after release SHALL be element 0.

Structure
REQ-030 Q8.8 width, the SAT_MAX/SAT_MIN constants (0x7FFF/0x8000) and the sat16 function SHALL live in the shared package used by the sigmoid stage.
REQ-031 Weights and buffer SHALL be register arrays in this module; no sub-module SHALL be instantiated.

Verification
REQ-032 Reset, en=0, 4 beats of x=0xFF -> res_dat=0x0000; state back to ARG; err_rdy never asserted.
REQ-033 en=1, x=4x0xFF, then err=0x0100 -> after UPD every w=0x003F; next vector x=4x0x80 -> res_dat=0x007E.
REQ-034 en=1, x=4x0xFF, err=0x7FFF repeated 5 times -> w saturates at 0x7FFF; next x=4x0xFF -> res_dat=0x7FFF.
REQ-035 res_rdy held 0 for 10 cycles -> res_stb and res_dat stable, arg_rdy=0 throughout; res_rdy=1 -> single transfer.
REQ-036 Assert rst=0 after 2 of 4 arg beats -> outputs at reset values; a fresh 4-beat vector gives the same result as from cold reset.
REQ-037 Random arg/err stb gaps and res_rdy backpressure, 1000 vectors -> res_dat matches the bit-exact reference model.
